// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian crossing unit.
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WALK  = 2'd2,
    FLASH = 2'd3
  } ped_state_t;

  localparam int DEF_DEB_CYCLES   = 4;
  localparam int DEF_WALK_CYCLES  = 8;
  localparam int DEF_FLASH_CYCLES = 4;

  // Light vector is packed as {G, Y, R}.
  localparam logic [2:0] LIGHT_G    = 3'b100;
  localparam logic [2:0] LIGHT_Y    = 3'b010;
  localparam logic [2:0] LIGHT_R    = 3'b001;
  localparam logic [2:0] LIGHT_NONE = 3'b000;

  // True when more than one bit is set.
  function automatic logic multi_light(input logic [2:0] lights);
    return (lights & (lights - 3'd1)) != LIGHT_NONE;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ped_btn_debounce.sv
// Button synchronizer and debouncer; emits one registered press pulse per
// qualified press.
module ped_btn_debounce
  import ped_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  input  logic Btn,
  output logic press
);

  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;

  // Count saturates at DEB_CYCLES so a held button cannot re-fire.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= Btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (!sync2) begin
        cnt <= '0;
      end else if (cnt != DW'(DEB_CYCLES)) begin
        cnt   <= cnt + DW'(1);
        press <= (cnt == DW'(DEB_CYCLES - 1));
      end
    end
  end

endmodule

// File: rtl/ped_crossing_unit.sv
// Pedestrian side of the stoplight: latches the crossing request and runs
// the walk / flashing don't-walk sequence off the controller's lights.
module ped_crossing_unit
  import ped_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int WALK_CYCLES  = DEF_WALK_CYCLES,
  parameter int FLASH_CYCLES = DEF_FLASH_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  input  logic Btn,
  input  logic SigG,
  input  logic SigY,
  input  logic SigR,
  output logic Ped,
  output logic Walk,
  output logic DontWalk,
  output logic Flash,
  output logic Fault
);

  localparam int PW = $clog2(max2(WALK_CYCLES, FLASH_CYCLES) + 1);

  ped_state_t    state, next_state;
  logic [PW-1:0] phase, phase_n;
  logic          prev_r;
  logic          press;
  logic          multi;
  logic          fresh_red;
  logic          abort;
  logic          fault_n;

  ped_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .CLK   (CLK),
    .RST   (RST),
    .Btn   (Btn),
    .press (press)
  );

  assign multi     = multi_light({SigG, SigY, SigR});
  assign fresh_red = SigR & ~prev_r;
  // Red must stay solely lit for the whole walk/flash window.
  assign abort     = ((state == WALK) || (state == FLASH)) && (!SigR || multi);
  assign fault_n   = Fault | multi | abort;

  always_comb begin
    next_state = state;
    phase_n    = phase;
    case (state)
      IDLE: begin
        if (press) next_state = REQ;
      end
      REQ: begin
        if (fresh_red && !multi) begin
          next_state = WALK;
          phase_n    = PW'(WALK_CYCLES - 1);
        end
      end
      WALK: begin
        if (abort) begin
          next_state = IDLE;
          phase_n    = '0;
        end else if (phase == '0) begin
          next_state = FLASH;
          phase_n    = PW'(FLASH_CYCLES - 1);
        end else begin
          phase_n = phase - PW'(1);
        end
      end
      FLASH: begin
        if (abort || phase == '0) begin
          next_state = IDLE;
          phase_n    = '0;
        end else begin
          phase_n = phase - PW'(1);
        end
      end
      default: begin
        next_state = IDLE;
        phase_n    = '0;
      end
    endcase
  end

  // Lamps are decoded from the next state so they change on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      phase    <= '0;
      prev_r   <= 1'b0;
      Ped      <= 1'b0;
      Walk     <= 1'b0;
      DontWalk <= 1'b1;
      Flash    <= 1'b0;
      Fault    <= 1'b0;
    end else begin
      state    <= next_state;
      phase    <= phase_n;
      prev_r   <= SigR;
      Ped      <= (next_state == REQ);
      Walk     <= (next_state == WALK);
      DontWalk <= (next_state != WALK);
      Flash    <= (next_state == FLASH);
      Fault    <= fault_n;
    end
  end

endmodule

// File: tb/tb_ped_crossing_unit.sv
// Directed bench for ped_crossing_unit: vector table plus corner sequences.
module tb_ped_crossing_unit;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic Btn = 1'b0;
  logic SigG = 1'b0;
  logic SigY = 1'b0;
  logic SigR = 1'b0;
  logic Ped, Walk, DontWalk, Flash, Fault;

  always #5 CLK = ~CLK;

  ped_crossing_unit dut (
    .CLK      (CLK),
    .RST      (RST),
    .Btn      (Btn),
    .SigG     (SigG),
    .SigY     (SigY),
    .SigR     (SigR),
    .Ped      (Ped),
    .Walk     (Walk),
    .DontWalk (DontWalk),
    .Flash    (Flash),
    .Fault    (Fault)
  );

  // Output word is {Ped, Walk, DontWalk, Flash, Fault}.
  localparam logic [4:0] O_IDLE  = 5'b00100;
  localparam logic [4:0] O_REQ   = 5'b10100;
  localparam logic [4:0] O_WALK  = 5'b01000;
  localparam logic [4:0] O_FLASH = 5'b00110;
  localparam logic [4:0] F       = 5'b00001;

  typedef struct {
    logic       rst, btn, g, y, r;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic rst, btn, g, y, r, input logic [4:0] exp);
    vec_t v;
    v.rst = rst; v.btn = btn; v.g = g; v.y = y; v.r = r; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic step(input logic rst, btn, g, y, r);
    @(negedge CLK);
    RST = rst; Btn = btn; SigG = g; SigY = y; SigR = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [4:0] exp);
    logic [4:0] act;
    act = {Ped, Walk, DontWalk, Flash, Fault};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got {Ped,Walk,DontWalk,Flash,Fault}=%b want %b",
               tag, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic b7 [7];
    logic [4:0] e_exp;
    b7 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset, then quiet idle on green.
    for (int i = 0; i < 2; i++)  add(1, 0, 1, 0, 0, O_IDLE);
    for (int i = 0; i < 20; i++) add(0, 0, 1, 0, 0, O_IDLE);

    // Normal crossing: button held edges 0..9, re-press during walk 21..26.
    for (int e = 0; e <= 36; e++) begin
      if (e >= 6 && e <= 19)       e_exp = O_REQ;
      else if (e >= 20 && e <= 27) e_exp = O_WALK;
      else if (e >= 28 && e <= 31) e_exp = O_FLASH;
      else                         e_exp = O_IDLE;
      add(0, logic'((e <= 9) || (e >= 21 && e <= 26)),
          logic'(e <= 13), logic'(e >= 14 && e <= 19), logic'(e >= 20), e_exp);
    end

    // Bounce: never DEB_CYCLES consecutive synced highs.
    for (int i = 0; i < 12; i++) add(0, (i < 7) ? b7[i] : 1'b0, 1, 0, 0, O_IDLE);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].btn, tbl[i].g, tbl[i].y, tbl[i].r);
      chk("vec", i, tbl[i].exp);
    end

    // Red already on when the request lands: must wait for a new rise.
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 0, 1); chk("red_pre", i, O_IDLE); end
    for (int i = 0; i <= 6; i++) begin
      step(0, 1, 0, 0, 1); chk("red_press", i, (i == 6) ? O_REQ : O_IDLE);
    end
    for (int i = 0; i < 4; i++) begin step(0, 0, 0, 0, 1); chk("red_hold", i, O_REQ); end
    step(0, 0, 0, 0, 0); chk("red_drop", 0, O_REQ);
    step(0, 0, 0, 0, 1); chk("red_rise", 0, O_WALK);
    for (int i = 1; i <= 11; i++) begin
      step(0, 0, 0, 0, 1); chk("red_seq", i, (i <= 7) ? O_WALK : O_FLASH);
    end
    step(0, 0, 0, 0, 1); chk("red_done", 0, O_IDLE);

    // Red drops mid-walk: abort and sticky fault.
    for (int i = 0; i <= 6; i++) begin
      step(0, 1, 0, 0, 1); chk("ab_press", i, (i == 6) ? O_REQ : O_IDLE);
    end
    step(0, 0, 0, 0, 0); chk("ab_drop", 0, O_REQ);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 0, 1); chk("ab_walk", i, O_WALK); end
    step(0, 0, 0, 0, 0); chk("ab_abort", 0, O_IDLE | F);

    // A full crossing still works while the fault is latched.
    step(0, 0, 1, 0, 0); chk("fc_idle", 0, O_IDLE | F);
    for (int i = 0; i <= 6; i++) begin
      step(0, 1, 1, 0, 0); chk("fc_press", i, (i == 6) ? (O_REQ | F) : (O_IDLE | F));
    end
    step(0, 0, 0, 1, 0); chk("fc_yel", 0, O_REQ | F);
    step(0, 0, 0, 0, 1); chk("fc_walk", 0, O_WALK | F);
    for (int i = 1; i <= 11; i++) begin
      step(0, 0, 0, 0, 1); chk("fc_seq", i, (i <= 7) ? (O_WALK | F) : (O_FLASH | F));
    end
    step(0, 0, 0, 0, 1); chk("fc_done", 0, O_IDLE | F);
    step(1, 0, 1, 0, 0); chk("fc_rst", 0, O_IDLE);

    // Illegal light combination in idle.
    step(0, 0, 1, 0, 1); chk("multi", 0, O_IDLE | F);
    step(0, 0, 1, 0, 0); chk("multi_sticky", 0, O_IDLE | F);

    // Reset in the middle of flash.
    step(1, 0, 1, 0, 0); chk("mf_rst0", 0, O_IDLE);
    for (int i = 0; i <= 6; i++) begin
      step(0, 1, 1, 0, 0); chk("mf_press", i, (i == 6) ? O_REQ : O_IDLE);
    end
    for (int i = 0; i < 8; i++) begin step(0, 0, 0, 0, 1); chk("mf_walk", i, O_WALK); end
    for (int i = 0; i < 2; i++) begin step(0, 0, 0, 0, 1); chk("mf_flash", i, O_FLASH); end
    step(1, 0, 0, 0, 1); chk("mf_rst", 0, O_IDLE);
    step(0, 0, 0, 0, 1); chk("mf_after", 0, O_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ped_crossing_unit.md
Name: ped_crossing_unit

Overview:
- Pedestrian-side counterpart of the stoplight controller: turns a raw crosswalk button into the controller's Ped request, and drives the walk indicators from the controller's SigG/SigY/SigR outputs.
- Sits between the physical button and lamp drivers on one side and the stoplight controller on the other.
- Owns request latching, request hold and release, the walk/flash timing, and a safety fault flag.

Parameters:
- DEB_CYCLES, 4, consecutive synchronized-high samples of Btn needed to register a press (>=1).
- WALK_CYCLES, 8, cycles Walk is held once a fresh red is seen (>=1).
- FLASH_CYCLES, 4, cycles of flashing don't-walk after Walk ends (>=1).

Ports:
- CLK  input  1  single clock; all state updates on posedge.
- RST  input  1  synchronous, active-high reset.
- Btn  input  1  raw asynchronous pedestrian button, active-high.
- SigG  input  1  green from stoplight controller.
- SigY  input  1  yellow from stoplight controller.
- SigR  input  1  red from stoplight controller.
- Ped  output  1  registered crossing request to the controller.
- Walk  output  1  walk lamp.
- DontWalk  output  1  don't-walk lamp.
- Flash  output  1  don't-walk flashing enable.
- Fault  output  1  sticky safety fault.

Behaviour:
- Reset (RST high at posedge): state IDLE, Ped=0, Walk=0, DontWalk=1, Flash=0, Fault=0. Sync flops, debounce counter, phase counter and prevR all clear to 0. Reset mid-WALK or mid-FLASH aborts immediately with no completion of the phase.
- Input conditioning:
  - Btn passes through a 2-flop synchronizer.
  - Debounce counter increments while the synced level is 1 and clears to 0 when it is 0. It saturates at DEB_CYCLES.
  - A press is a single-cycle pulse when the counter reaches DEB_CYCLES. A held button produces one press only; it must drop and re-qualify to press again.
  - Ped rises on the edge 2+DEB_CYCLES after the first edge that samples Btn=1, with Btn held throughout.
- prevR register stores SigR from the previous cycle. A fresh red is SigR=1 and prevR=0.
- States (encoded in ped_pkg):
  - IDLE: DontWalk=1. On press, go to REQ and set Ped=1 on the same edge.
  - REQ: Ped held at 1 and DontWalk=1. Presses are absorbed.
    - On a fresh red, go to WALK: Ped=0, Walk=1, DontWalk=0, phase counter loaded with WALK_CYCLES-1.
    - A red that was already high when REQ was entered is not used; REQ waits for the next rising edge of SigR.
  - WALK: Walk=1 for exactly WALK_CYCLES cycles. The counter decrements each cycle. At 0, go to FLASH: Walk=0, DontWalk=1, Flash=1, counter loaded with FLASH_CYCLES-1.
  - FLASH: DontWalk=1 and Flash=1 for exactly FLASH_CYCLES cycles, then go to IDLE with Flash=0.
  - Presses during WALK and FLASH are ignored (lockout). A press in the same cycle as the FLASH to IDLE transition is also ignored.
- Fault conditions:
  - SigR=0 in any cycle while in WALK or FLASH: set Fault=1, go to IDLE on the same edge (Walk=0, Flash=0, DontWalk=1, Ped=0).
  - More than one of SigG/SigY/SigR high in any state: set Fault=1. If in WALK or FLASH, also abort to IDLE.
  - Fault stays at 1 until RST. The unit keeps operating normally while Fault=1.
- Simultaneous events:
  - A fault abort takes priority over counter expiry.
  - In REQ, a fresh red on the same cycle as a multi-light fault sets Fault and stays in REQ.
- Widths: counters are $clog2(max(WALK_CYCLES,FLASH_CYCLES)+1) bits; the debounce counter is $clog2(DEB_CYCLES+1) bits. No wrap-around is allowed.
- All outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- ped_pkg holds:
  - the state enum (IDLE, REQ, WALK, FLASH);
  - light-combination check constants;
  - default timing constants.
- Sub-module ped_btn_debounce contains the synchronizer, debounce counter and press pulse generation. It is parameterized by DEB_CYCLES and clocked and reset by the same CLK and RST.
- The top level holds the FSM, phase counter, prevR and Fault.

Test Plan:
- Reset then idle: RST high 2 cycles, then low with Btn=0 and SigG=1 -> Ped=0, Walk=0, DontWalk=1, Flash=0, Fault=0 for 20 cycles.
- Normal crossing (defaults): Btn=1 held from edge 0 -> Ped=1 at edge 6. Then SigG to SigY to SigR, with SigR rising at edge 20 -> Ped=0 and Walk=1 for edges 20-27, Flash=1 for edges 28-31, then back to IDLE.
- Bounce rejection: Btn toggles 1,1,0,1,1,1,0 -> Ped never asserts. Btn held 10 cycles -> exactly one REQ entry; a re-press during WALK is ignored.
- Red already on: press while SigR=1 steady -> Ped held and Walk=0. SigR dropped to 0 then back to 1 -> Walk asserts on that rising edge.
- Fault abort: SigR forced to 0 at cycle 3 of WALK -> Walk=0, DontWalk=1, Fault=1 on the next edge. Fault stays 1 through a later normal crossing until RST.
- Illegal lights and reset mid-op: SigG=SigR=1 in IDLE -> Fault=1. RST asserted mid-FLASH -> all outputs return to reset values on that edge.
